button_event: RTL and testbench

//  Converts one debounced pushbutton level into single-cycle event pulses: press,

---
 rtl/button_event_pkg.sv | 26 ++
 rtl/button_event.sv | 128 ++++++++++++
 tb/tb_button_event.sv | 136 +++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// ---------------------------------------------------------------------------
// button_event_pkg
//   Shared types and timing defaults for the pushbutton event generator.
//   - state_t : FSM state encoding (IDLE=0, DOWN=1, LONG=2; code 3 is unused
//               and recovers to IDLE).
//   - default timing for a 27 MHz system clock (0.5 s long press, 0.1 s repeat).
// ---------------------------------------------------------------------------
package button_event_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DOWN = 2'd1,
    S_LONG = 2'd2
  } state_t;

  // 27 MHz defaults; instantiators override these through parameters.
  localparam int DEF_LONG_DELAY    = 13_500_000;
  localparam int DEF_REPEAT_PERIOD = 2_700_000;
  localparam int DEF_NBITS         = 24;

  // Held states drive the 'held' level output.
  function automatic logic is_held(input state_t s);
    return (s == S_DOWN) || (s == S_LONG);
  endfunction

endpackage

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//   Turns one debounced, clk-synchronous button level into single-cycle event
//   pulses (press, release, long press, auto-repeat) plus a 'held' level.
//   All outputs are registered.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   btn           in   debounced button level, active-high
//   press         out  1-cycle pulse: button went down
//   release_evt   out  1-cycle pulse: button went up
//   long_press    out  1-cycle pulse: held for LONG_DELAY cycles
//   repeat_evt    out  1-cycle pulse every REPEAT_PERIOD cycles while long
//   held          out  level: 1 while in DOWN or LONG
//
//   'release' and 'repeat' are SystemVerilog keywords, hence the _evt names.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | button up, waiting for btn=1
// DOWN  | button down, counting towards LONG_DELAY
// LONG  | long press reached, counting repeat periods
// ---------------------------------------------------------------------------
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_DELAY    = DEF_LONG_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int NBITS         = DEF_NBITS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam logic [NBITS-1:0] LONG_LAST   = NBITS'(LONG_DELAY - 1);
  localparam logic [NBITS-1:0] REPEAT_LAST = NBITS'(REPEAT_PERIOD - 1);

  state_t           state;
  logic [NBITS-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      // Pulses default low so each is high for exactly one cycle.
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (btn) begin
            state <= S_DOWN;
            press <= 1'b1;
            count <= '0;
          end
        end

        S_DOWN: begin
          // Release is tested first so it wins over long_press.
          if (!btn) begin
            state       <= S_IDLE;
            release_evt <= 1'b1;
            count       <= '0;
          end else if (count == LONG_LAST) begin
            state      <= S_LONG;
            long_press <= 1'b1;
            count      <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end

        S_LONG: begin
          if (!btn) begin
            state       <= S_IDLE;
            release_evt <= 1'b1;
            count       <= '0;
          end else if (REPEAT_EN && (count == REPEAT_LAST)) begin
            repeat_evt <= 1'b1;
            count      <= '0;
          end else if (count != REPEAT_LAST) begin
            // With repeat disabled the count parks at REPEAT_LAST.
            count <= count + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase

      held <= is_held(next_state(state, btn, count));
    end
  end

  // Mirror of the state transitions above, used only to register 'held'
  // so it rises with press and falls with release in the same cycle.
  function automatic state_t next_state(input state_t s, input logic b,
                                        input logic [NBITS-1:0] c);
    state_t n;
    n = s;
    case (s)
      S_IDLE:  n = b ? S_DOWN : S_IDLE;
      S_DOWN:  n = !b ? S_IDLE : ((c == LONG_LAST) ? S_LONG : S_DOWN);
      S_LONG:  n = b ? S_LONG : S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

  logic clk = 1'b0;
  logic reset;
  logic btn, btn2;
  logic press, release_evt, long_press, repeat_evt, held;
  logic press2, release2, long2, repeat2, held2;

  int nchecks = 0;
  int nerr    = 0;
  int nlong, nrep;

  always #5 clk = ~clk;

  button_event #(.LONG_DELAY(8), .REPEAT_PERIOD(3), .REPEAT_EN(1'b1), .NBITS(4)) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .press(press), .release_evt(release_evt), .long_press(long_press),
    .repeat_evt(repeat_evt), .held(held)
  );

  button_event #(.LONG_DELAY(8), .REPEAT_PERIOD(3), .REPEAT_EN(1'b0), .NBITS(4)) dut_norep (
    .clk(clk), .reset(reset), .btn(btn2),
    .press(press2), .release_evt(release2), .long_press(long2),
    .repeat_evt(repeat2), .held(held2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic r,
                         input logic l, input logic rp, input logic h);
    chk({tag, ".press"}, press, p);
    chk({tag, ".release"}, release_evt, r);
    chk({tag, ".long_press"}, long_press, l);
    chk({tag, ".repeat"}, repeat_evt, rp);
    chk({tag, ".held"}, held, h);
  endtask

  initial begin
    // 1: reset while btn=1, then release reset -> fresh press
    reset = 1'b1; btn = 1'b1; btn2 = 1'b0;
    tick();
    chk_all("t1_rst_a", 0, 0, 0, 0, 0);
    tick();
    chk_all("t1_rst_b", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("t1_press", 1, 0, 0, 0, 1);
    btn = 1'b0;
    tick();
    chk_all("t1_release", 0, 1, 0, 0, 0);
    tick();
    chk_all("t1_idle", 0, 0, 0, 0, 0);

    // 2: single-cycle btn pulse
    btn = 1'b1;
    tick();
    chk_all("t2_c1", 1, 0, 0, 0, 1);
    btn = 1'b0;
    tick();
    chk_all("t2_c2", 0, 1, 0, 0, 0);
    tick();
    chk_all("t2_c3", 0, 0, 0, 0, 0);

    // 3: hold 20 cycles
    btn = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      chk_all($sformatf("t3_c%0d", c),
              (c == 1), (c == 21), (c == 9),
              (c == 12 || c == 15 || c == 18), (c >= 1 && c <= 20));
      btn = (c < 20);
    end

    // 4: drop btn exactly when count==7 in DOWN (8 high samples)
    btn = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_all($sformatf("t4_c%0d", c), (c == 1), (c == 9), 1'b0, 1'b0, (c <= 8));
      btn = (c < 8);
    end

    // 5: repeat disabled, hold 30 cycles
    nlong = 0; nrep = 0;
    btn2 = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (long2) nlong++;
      if (repeat2) nrep++;
      if (c == 9) chk("t5_long_at_9", long2, 1'b1);
      if (c <= 30) chk($sformatf("t5_held_c%0d", c), held2, 1'b1);
      if (c == 31) chk("t5_release", release2, 1'b1);
      btn2 = (c < 30);
    end
    chk_int("t5_long_count", nlong, 1);
    chk_int("t5_repeat_count", nrep, 0);
    chk("t5_held_after", held2, 1'b0);

    // 6: async reset mid-cycle while in LONG
    btn = 1'b1;
    for (int c = 1; c <= 10; c++) tick();
    chk("t6_in_long_held", held, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_all("t6_async", 0, 0, 0, 0, 0);
    tick();
    chk_all("t6_rst_hold", 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    tick();
    chk_all("t6_fresh_press", 1, 0, 0, 0, 1);
    tick();
    chk_all("t6_after", 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
